// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: produces per-stage stall vectors, sequences
// multi-cycle divides with a timeout, and issues registered flush/redirect
// commands for exceptions.
//
// Handshake note: all request inputs are sampled on the rising clock edge.
// stallreq_id/stallreq_mem are levels. div_start/div_ready/flush_req are
// one-cycle pulses. stall is combinational from the current state and the
// present inputs. flush, flush_pc and div_abort come from flops and change
// only on a clock edge or on reset.
module pipeline_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_mem,
  input  logic             div_start,
  input  logic             div_ready,
  input  logic             flush_req,
  input  logic [31:0]      exc_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      flush_pc,
  output logic             div_abort,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       timeout;
  logic       abort_nxt;

  // The last permitted DIV_WAIT cycle is the one where the counter reads
  // DIV_TIMEOUT-1, so the divide gets exactly DIV_TIMEOUT cycles.
  assign timeout = (wait_cnt == 8'(DIV_TIMEOUT - 1));

  // Next-state selection; flush_req always wins, and any exit from
  // DIV_WAIT other than div_ready requests an abort pulse.
  always_comb begin
    state_nxt = state;
    abort_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req)      state_nxt = FLUSH;
        else if (div_start) state_nxt = DIV_WAIT;
      end
      DIV_WAIT: begin
        if (flush_req) begin
          state_nxt = FLUSH;
          abort_nxt = 1'b1;
        end else if (div_ready) begin
          state_nxt = IDLE;
        end else if (timeout) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_req) state_nxt = FLUSH;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register plus the registered flush and abort commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush     <= 1'b0;
      div_abort <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush     <= (state_nxt == FLUSH);
      div_abort <= abort_nxt;
    end
  end

  // Wait counter sits at zero outside DIV_WAIT, so it reads zero on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    wait_cnt <= 8'd0;
    else if (state == DIV_WAIT) wait_cnt <= wait_cnt + 8'd1;
    else                        wait_cnt <= 8'd0;
  end

  // Redirect address captured on the edge that sees the flush request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            flush_pc <= 32'h0;
    else if (flush_req) flush_pc <= exc_pc;
  end

  // Prioritised stall vector; div_ready releases the EX hold immediately.
  always_comb begin
    stall = 6'b000000;
    if (rst)                                 stall = 6'b000000;
    else if (state == FLUSH)                 stall = 6'b000000;
    else if (stallreq_mem)                   stall = 6'b011111;
    else if (state == DIV_WAIT && !div_ready) stall = 6'b001111;
    else if (state == IDLE && div_start)     stall = 6'b001111;
    else if (stallreq_id)                    stall = 6'b000111;
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 stall_cnt <= '0;
    else if (stall[0] && (stall_cnt != '1))  stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (default parameters and a small
// one with DIV_TIMEOUT=4, CNT_W=4) share stimulus and are compared against
// a cycle-level behavioural model kept here.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_mem, div_start, div_ready, flush_req;
  logic [31:0] exc_pc;

  logic [5:0]  stall_b, stall_s;
  logic        flush_b, flush_s, ab_b, ab_s;
  logic [31:0] pc_b, pc_s;
  logic [15:0] cnt_b;
  logic [3:0]  cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  pipeline_ctrl dut_big (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
    .div_start(div_start), .div_ready(div_ready), .flush_req(flush_req), .exc_pc(exc_pc),
    .stall(stall_b), .flush(flush_b), .flush_pc(pc_b), .div_abort(ab_b), .stall_cnt(cnt_b)
  );

  pipeline_ctrl #(.DIV_TIMEOUT(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_mem(stallreq_mem),
    .div_start(div_start), .div_ready(div_ready), .flush_req(flush_req), .exc_pc(exc_pc),
    .stall(stall_s), .flush(flush_s), .flush_pc(pc_s), .div_abort(ab_s), .stall_cnt(cnt_s)
  );

  // ---------------- reference model ----------------
  // m_age: -1 when no divide is pending, else number of wait cycles already
  // completed. m_fl: a flush command is being presented this cycle.
  int          tmo[2]  = '{64, 4};
  int          cmax[2] = '{65535, 15};
  int          m_age[2];
  bit          m_fl[2];
  logic [31:0] m_pc[2];
  bit          m_ab[2];
  int          m_cnt[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_age[k] = -1; m_fl[k] = 1'b0; m_pc[k] = 32'h0; m_ab[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  function automatic logic [5:0] exp_stall(int k);
    if (rst)                            return 6'b000000;
    if (m_fl[k])                        return 6'b000000;
    if (stallreq_mem)                   return 6'b011111;
    if (m_age[k] >= 0 && !div_ready)    return 6'b001111;
    if (m_age[k] < 0 && div_start)      return 6'b001111;
    if (stallreq_id)                    return 6'b000111;
    return 6'b000000;
  endfunction

  function automatic logic [5:0]  a_stall(int k); return (k == 0) ? stall_b : stall_s; endfunction
  function automatic logic        a_flush(int k); return (k == 0) ? flush_b : flush_s; endfunction
  function automatic logic [31:0] a_pc(int k);    return (k == 0) ? pc_b : pc_s;       endfunction
  function automatic logic        a_ab(int k);    return (k == 0) ? ab_b : ab_s;       endfunction
  function automatic logic [15:0] a_cnt(int k);   return (k == 0) ? cnt_b : {12'h0, cnt_s}; endfunction

  // Advance the model by one rising edge, then move the DUTs to the next
  // falling edge, where new stimulus is applied.
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      logic [5:0] st;
      st = exp_stall(k);
      if (st[0] && m_cnt[k] < cmax[k]) m_cnt[k]++;
      m_ab[k] = 1'b0;
      if (flush_req) begin
        if (m_age[k] >= 0) m_ab[k] = 1'b1;
        m_fl[k] = 1'b1; m_age[k] = -1; m_pc[k] = exc_pc;
      end else if (m_fl[k]) begin
        m_fl[k] = 1'b0;
      end else if (m_age[k] >= 0) begin
        if (div_ready) m_age[k] = -1;
        else if (m_age[k] + 1 >= tmo[k]) begin m_age[k] = -1; m_ab[k] = 1'b1; end
        else m_age[k]++;
      end else if (div_start) begin
        m_age[k] = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    stallreq_id = 0; stallreq_mem = 0; div_start = 0; div_ready = 0; flush_req = 0; exc_pc = 32'h0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      stallreq_id = 1'($urandom); stallreq_mem = 1'($urandom); div_start = 1'($urandom);
      div_ready = 1'($urandom); flush_req = 1'($urandom); exc_pc = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (a_stall(k) !== 6'b0 || a_flush(k) !== 1'b0 || a_pc(k) !== 32'h0 ||
            a_ab(k) !== 1'b0 || a_cnt(k) !== 16'h0) begin
          n_fail++;
          $display("FAIL reset[%0d]: got stall=%b flush=%b pc=%h abort=%b cnt=%h, expected all zero",
                   k, a_stall(k), a_flush(k), a_pc(k), a_ab(k), a_cnt(k));
        end
      end
      @(negedge clk);
    end
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_stall_id();
    apply_reset();
    stallreq_id = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if (stall_b !== 6'b000111 || stall_b !== exp_stall(0)) begin
        n_fail++; $display("FAIL stall_id: got %b expected 000111", stall_b);
      end
      tick();
    end
    stallreq_id = 1'b0;
    #1;
    n_tests++;
    if (cnt_b !== 16'd2 || cnt_b !== 16'(m_cnt[0])) begin
      n_fail++; $display("FAIL stall_id_cnt: got %0d expected 2", cnt_b);
    end
    n_tests++;
    if (stall_b !== 6'b0) begin
      n_fail++; $display("FAIL stall_id_release: got %b expected 000000", stall_b);
    end
  endtask

  task automatic test_div_ready();
    apply_reset();
    div_start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_tests++;
      if (stall_b !== 6'b001111 || ab_b !== 1'b0) begin
        n_fail++; $display("FAIL div_wait c%0d: got stall=%b abort=%b expected 001111/0", c, stall_b, ab_b);
      end
      tick();
      div_start = 1'b0;
    end
    div_ready = 1'b1;
    #1;
    n_tests++;
    if (stall_b !== 6'b0) begin
      n_fail++; $display("FAIL div_ready_release: got %b expected 000000", stall_b);
    end
    tick();
    div_ready = 1'b0;
    #1;
    n_tests++;
    if (stall_b !== 6'b0 || ab_b !== 1'b0 || ab_b !== m_ab[0]) begin
      n_fail++; $display("FAIL div_ready_exit: got stall=%b abort=%b expected 000000/0", stall_b, ab_b);
    end
    n_tests++;
    if (ab_s !== m_ab[1] || stall_s !== exp_stall(1)) begin
      n_fail++; $display("FAIL div_ready_small: got abort=%b stall=%b expected %b/%b", ab_s, stall_s, m_ab[1], exp_stall(1));
    end
  endtask

  task automatic test_timeout();
    int n_wait = 0;
    int n_ab   = 0;
    apply_reset();
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (stall_s == 6'b001111) n_wait++;
      if (ab_s) n_ab++;
      n_tests++;
      if (ab_s !== m_ab[1] || stall_s !== exp_stall(1)) begin
        n_fail++; $display("FAIL timeout c%0d: got abort=%b stall=%b expected %b/%b", c, ab_s, stall_s, m_ab[1], exp_stall(1));
      end
      tick();
    end
    n_tests++;
    if (n_wait != 4 || n_ab != 1) begin
      n_fail++; $display("FAIL timeout_counts: got wait=%0d aborts=%0d expected 4/1", n_wait, n_ab);
    end
  endtask

  task automatic test_flush_div();
    apply_reset();
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    repeat (3) tick();
    flush_req = 1'b1; exc_pc = 32'h0000_0040; stallreq_mem = 1'b1; div_ready = 1'b1;
    #1;
    n_tests++;
    if (stall_b !== 6'b011111) begin
      n_fail++; $display("FAIL flush_div_stall: got %b expected 011111", stall_b);
    end
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if (flush_b !== 1'b1 || pc_b !== 32'h40 || stall_b !== 6'b0 || ab_b !== 1'b1) begin
      n_fail++; $display("FAIL flush_div_cmd: got flush=%b pc=%h stall=%b abort=%b expected 1/00000040/000000/1",
                         flush_b, pc_b, stall_b, ab_b);
    end
    tick();
    stallreq_id = 1'b1;
    #1;
    n_tests++;
    if (flush_b !== 1'b0 || ab_b !== 1'b0 || stall_b !== 6'b000111 || pc_b !== 32'h40) begin
      n_fail++; $display("FAIL flush_div_idle: got flush=%b abort=%b stall=%b pc=%h expected 0/0/000111/00000040",
                         flush_b, ab_b, stall_b, pc_b);
    end
    tick();
    stallreq_id = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc1, pc2;
    apply_reset();
    pc1 = $urandom; pc2 = $urandom;
    flush_req = 1'b1; exc_pc = pc1;
    tick();
    exc_pc = pc2; div_start = 1'b1;
    #1;
    n_tests++;
    if (flush_b !== 1'b1 || pc_b !== pc1 || stall_b !== 6'b0) begin
      n_fail++; $display("FAIL b2b_first: got flush=%b pc=%h stall=%b expected 1/%h/000000", flush_b, pc_b, stall_b, pc1);
    end
    tick();
    flush_req = 1'b0; div_start = 1'b0;
    #1;
    n_tests++;
    if (flush_b !== 1'b1 || pc_b !== pc2 || ab_b !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got flush=%b pc=%h abort=%b expected 1/%h/0", flush_b, pc_b, ab_b, pc2);
    end
    tick();
    #1;
    n_tests++;
    if (flush_b !== 1'b0 || stall_b !== 6'b0 || pc_b !== pc2) begin
      n_fail++; $display("FAIL b2b_idle: got flush=%b stall=%b pc=%h expected 0/000000/%h", flush_b, stall_b, pc_b, pc2);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    stallreq_id = 1'b1;
    repeat (20) tick();
    stallreq_id = 1'b0;
    #1;
    n_tests++;
    if (cnt_s !== 4'hF || cnt_b !== 16'd20) begin
      n_fail++; $display("FAIL saturate: got small=%h big=%0d expected f/20", cnt_s, cnt_b);
    end
  endtask

  task automatic test_reset_mid_div();
    apply_reset();
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (stall_b !== 6'b0 || flush_b !== 1'b0 || ab_b !== 1'b0 || cnt_b !== 16'h0 || pc_b !== 32'h0) begin
      n_fail++; $display("FAIL mid_div_reset: got stall=%b flush=%b abort=%b cnt=%h pc=%h expected all zero",
                         stall_b, flush_b, ab_b, cnt_b, pc_b);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_tests++;
      if (stall_b !== 6'b0 || ab_b !== 1'b0 || flush_b !== 1'b0 || ab_s !== 1'b0 || flush_s !== 1'b0) begin
        n_fail++; $display("FAIL mid_div_after c%0d: got stall=%b abort=%b/%b flush=%b/%b expected 0",
                           c, stall_b, ab_b, ab_s, flush_b, flush_s);
      end
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      stallreq_id  = ($urandom_range(0, 2) == 0);
      stallreq_mem = ($urandom_range(0, 4) == 0);
      div_start    = ($urandom_range(0, 3) == 0);
      div_ready    = ($urandom_range(0, 15) == 0);
      flush_req    = ($urandom_range(0, 24) == 0);
      exc_pc       = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (a_stall(k) !== exp_stall(k) || a_flush(k) !== m_fl[k] || a_pc(k) !== m_pc[k] ||
            a_ab(k) !== m_ab[k] || a_cnt(k) !== 16'(m_cnt[k])) begin
          n_fail++;
          $display("FAIL random c%0d[%0d]: got stall=%b flush=%b pc=%h abort=%b cnt=%h expected %b/%b/%h/%b/%h",
                   c, k, a_stall(k), a_flush(k), a_pc(k), a_ab(k), a_cnt(k),
                   exp_stall(k), m_fl[k], m_pc[k], m_ab[k], 16'(m_cnt[k]));
        end
      end
      if (rst) begin
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    clear_inputs();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_stall_id();
    test_div_ready();
    test_timeout();
    test_flush_div();
    test_back_to_back();
    test_saturate();
    test_reset_mid_div();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
